// File: rtl/onchip_arb_pkg.sv
// Shared constants and types for the two-master on-chip RAM arbiter.
// Contents: bus widths, RAM depth, master index type, request payload struct
// and a saturating-increment helper for the statistics counters.
package onchip_arb_pkg;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned DEPTH  = 6500;
   localparam int unsigned STAT_W = 16;

   typedef logic mst_idx_t;

   typedef struct packed {
      logic [ADDR_W-1:0] address;
      logic [BE_W-1:0]   byteenable;
      logic              read;
      logic              write;
      logic [DATA_W-1:0] writedata;
   } mst_req_t;

   // Counter increment that sticks at all-ones.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-to-arbiter link, one instance per master.
// master modport: drives address/byteenable/read/write/writedata,
//                 receives waitrequest/readdata/readdatavalid.
// slave modport:  the arbiter side of the same link.
interface onchip_mem_arbiter_if;
   import onchip_arb_pkg::*;

   logic [ADDR_W-1:0] address;
   logic [BE_W-1:0]   byteenable;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] writedata;
   logic              waitrequest;
   logic [DATA_W-1:0] readdata;
   logic              readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );

endinterface

// File: rtl/onchip_arb_rr2.sv
// Two-way round-robin grant logic, purely combinational.
// Ports: req[1:0] requests, last_gnt index granted most recently,
//        gnt_c[1:0] one-hot grant (zero when nobody requests).
module onchip_arb_rr2
   import onchip_arb_pkg::*;
(
   input  logic [1:0] req,
   input  mst_idx_t   last_gnt,
   output logic [1:0] gnt_c
);

   // On contention the master that was not granted last wins.
   always_comb begin
      gnt_c = 2'b00;
      if (req == 2'b11) gnt_c = last_gnt ? 2'b01 : 2'b10;
      else              gnt_c = req;
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter placing two Avalon-MM masters in front of a
// single-port 32-bit on-chip RAM with fixed 1-cycle read latency.
// Ports: clk, reset (async, active-high); m0/m1 master links (slave modport);
//        mem_* RAM pins; stat_grant0/stat_grant1/stat_conflict statistics.
// Build option: define ONCHIP_ARB_STATS_EN to enable the saturating 16-bit
// statistics counters; otherwise the stat ports are tied to zero.
module onchip_mem_arbiter
   import onchip_arb_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   onchip_mem_arbiter_if.slave  m0,
   onchip_mem_arbiter_if.slave  m1,
   output logic [ADDR_W-1:0]    mem_address,
   output logic [BE_W-1:0]      mem_byteenable,
   output logic                 mem_chipselect,
   output logic                 mem_write,
   output logic [DATA_W-1:0]    mem_writedata,
   output logic                 mem_clken,
   input  logic [DATA_W-1:0]    mem_readdata,
   output logic [STAT_W-1:0]    stat_grant0,
   output logic [STAT_W-1:0]    stat_grant1,
   output logic [STAT_W-1:0]    stat_conflict
);

   mst_req_t   r0, r1, sel_req;
   logic [1:0] req, gnt;
   logic       granted, rd_vld;
   mst_idx_t   last_gnt, sel, rd_id;

   assign r0 = '{address: m0.address, byteenable: m0.byteenable, read: m0.read,
                 write: m0.write, writedata: m0.writedata};
   assign r1 = '{address: m1.address, byteenable: m1.byteenable, read: m1.read,
                 write: m1.write, writedata: m1.writedata};

   assign req = {r1.read | r1.write, r0.read | r0.write};

   onchip_arb_rr2 u_rr2 (
      .req      (req),
      .last_gnt (last_gnt),
      .gnt_c    (gnt)
   );

   assign granted = |gnt;
   assign sel     = mst_idx_t'(gnt[1]);
   assign sel_req = sel ? r1 : r0;

   assign m0.waitrequest = req[0] & ~gnt[0];
   assign m1.waitrequest = req[1] & ~gnt[1];

   // RAM pins follow the granted master; all zero when idle.
   always_comb begin
      mem_chipselect = 1'b0;
      mem_address    = '0;
      mem_byteenable = '0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      if (granted) begin
         mem_chipselect = 1'b1;
         mem_address    = sel_req.address;
         mem_byteenable = sel_req.byteenable;
         mem_write      = sel_req.write;
         mem_writedata  = sel_req.writedata;
      end
   end

   assign mem_clken = 1'b1;

   // Arbitration history and in-flight read tag (write wins over read).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_gnt <= 1'b1;
         rd_vld   <= 1'b0;
         rd_id    <= 1'b0;
      end else begin
         if (granted) last_gnt <= sel;
         rd_vld <= granted & ~sel_req.write;
         rd_id  <= sel;
      end
   end

   assign m0.readdatavalid = rd_vld & (rd_id == 1'b0);
   assign m1.readdatavalid = rd_vld & (rd_id == 1'b1);
   assign m0.readdata      = m0.readdatavalid ? mem_readdata : '0;
   assign m1.readdata      = m1.readdatavalid ? mem_readdata : '0;

`ifdef ONCHIP_ARB_STATS_EN
   logic [STAT_W-1:0] cnt_g0, cnt_g1, cnt_cf;

   // Saturating grant / contention counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_g0 <= '0;
         cnt_g1 <= '0;
         cnt_cf <= '0;
      end else begin
         if (gnt[0])  cnt_g0 <= sat_inc(cnt_g0);
         if (gnt[1])  cnt_g1 <= sat_inc(cnt_g1);
         if (&req)    cnt_cf <= sat_inc(cnt_cf);
      end
   end

   assign stat_grant0   = cnt_g0;
   assign stat_grant1   = cnt_g1;
   assign stat_conflict = cnt_cf;
`else
   assign stat_grant0   = '0;
   assign stat_grant1   = '0;
   assign stat_conflict = '0;
`endif

endmodule
